// File: rtl/sarm_pkg.sv
// Shared SARM definitions: SRAM controller state encoding and memory-map constants.
package sarm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WAIT,
        DONE
    } sram_state_t;

    localparam logic [31:0] DATA_BASE   = 32'd1024;
    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 16;

endpackage

// File: rtl/sram_controller.sv
// Word-wide memory responder for the SARM MEM stage: each 32-bit access is split
// into two 16-bit cycles on an external asynchronous SRAM, then padded to WAIT_CYCLES.
module sram_controller
    import sarm_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ce_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    // Counter preload for the WAIT stretch; unused when WAIT_CYCLES == 3.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 4) ? 4'(WAIT_CYCLES - 4) : 4'd0;

    sram_state_t state, next_state;
    logic [3:0]             cnt;
    logic [SRAM_DATA_W-1:0] low_half;
    logic [16:0]            word;
    logic                   do_write;

    assign word      = 17'((address - DATA_BASE) >> 2);
    assign do_write  = wr_en & ~rd_en;
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            low_half  <= '0;
            read_data <= '0;
        end else begin
            state <= next_state;
            case (state)
                LOW: begin
                    if (!do_write) low_half <= sram_dq_in;
                end
                HIGH: begin
                    if (!do_write) read_data <= {sram_dq_in, low_half};
                    cnt <= WAIT_LOAD;
                end
                WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state  = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        case (state)
            IDLE: begin
                ready = ~(rd_en | wr_en);
                if (rd_en | wr_en) next_state = LOW;
            end
            LOW: begin
                sram_addr = {word, 1'b0};
                if (do_write) begin
                    sram_dq_out = write_data[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end else begin
                    sram_oe_n = 1'b0;
                end
                next_state = HIGH;
            end
            HIGH: begin
                sram_addr = {word, 1'b1};
                if (do_write) begin
                    sram_dq_out = write_data[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end else begin
                    sram_oe_n = 1'b0;
                end
                next_state = (WAIT_CYCLES == 3) ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) next_state = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: two instances (WAIT_CYCLES 5 and 3), each
// with a small synchronous-write SRAM model behind its pins.
module tb_sram_controller;
    import sarm_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] data;
        int unsigned lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic [31:0] rdata0, rdata1;
    logic        rdy0, rdy1;
    logic [17:0] saddr0, saddr1;
    logic [15:0] dqi0, dqi1, dqo0, dqo1;
    logic        dqoe0, dqoe1, we_n0, we_n1, oe_n0, oe_n1;
    logic        ce_n0, ce_n1, ub_n0, ub_n1, lb_n0, lb_n1;

    sram_controller #(.WAIT_CYCLES(5)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(addr0),
        .write_data(wd0), .read_data(rdata0), .ready(rdy0), .sram_addr(saddr0),
        .sram_dq_in(dqi0), .sram_dq_out(dqo0), .sram_dq_oe(dqoe0),
        .sram_we_n(we_n0), .sram_oe_n(oe_n0), .sram_ce_n(ce_n0),
        .sram_ub_n(ub_n0), .sram_lb_n(lb_n0)
    );

    sram_controller #(.WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
        .write_data(wd1), .read_data(rdata1), .ready(rdy1), .sram_addr(saddr1),
        .sram_dq_in(dqi1), .sram_dq_out(dqo1), .sram_dq_oe(dqoe1),
        .sram_we_n(we_n1), .sram_oe_n(oe_n1), .sram_ce_n(ce_n1),
        .sram_ub_n(ub_n1), .sram_lb_n(lb_n1)
    );

    logic [15:0] mem0 [0:63];
    logic [15:0] mem1 [0:63];
    always @(posedge clk) if (!we_n0) mem0[saddr0[5:0]] <= dqo0;
    always @(posedge clk) if (!we_n1) mem1[saddr1[5:0]] <= dqo1;
    assign dqi0 = mem0[saddr0[5:0]];
    assign dqi1 = mem1[saddr1[5:0]];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned compared = 0;
    int unsigned mismatched = 0;
    int unsigned start0, start1;
    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [34:0] ent(input logic we, input logic [17:0] a, input logic [15:0] d);
        return {we, a, d};
    endfunction

    // Monitor: whenever an instance presents ready with a request held, pop and compare.
    task automatic mon(input int inst);
        exp_t        e;
        logic [31:0] rd;
        int unsigned lat;
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            check($sformatf("unexpected_ready%0d", inst), 64'(1), 64'(0));
            return;
        end
        if (inst == 0) begin
            e = q0.pop_front(); rd = rdata0; lat = cyc - start0;
        end else begin
            e = q1.pop_front(); rd = rdata1; lat = cyc - start1;
        end
        check({e.name, "_latency"}, 64'(lat), 64'(e.lat));
        check({e.name, "_read_data"}, 64'(rd), 64'(e.data));
    endtask

    always @(negedge clk) begin
        if ((rd0 | wr0) && rdy0) mon(0);
        if ((rd1 | wr1) && rdy1) mon(1);
    end

    task automatic issue(input int inst, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_data, input int unsigned lat,
                         input logic [34:0] e0, input logic [34:0] e1, input string nm);
        exp_t        e;
        logic [34:0] log_e [4];
        int          n;
        logic        done;
        logic        p_we_n, p_oe_n, p_rdy;
        logic [17:0] p_addr;
        logic [15:0] p_dq;
        e.name = nm; e.data = exp_data; e.lat = lat;
        @(posedge clk); #1;
        if (inst == 0) begin
            q0.push_back(e); rd0 = rd; wr0 = wr; addr0 = a; wd0 = wd; start0 = cyc;
        end else begin
            q1.push_back(e); rd1 = rd; wr1 = wr; addr1 = a; wd1 = wd; start1 = cyc;
        end
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (inst == 0) begin
                p_we_n = we_n0; p_oe_n = oe_n0; p_addr = saddr0; p_dq = dqo0; p_rdy = rdy0;
            end else begin
                p_we_n = we_n1; p_oe_n = oe_n1; p_addr = saddr1; p_dq = dqo1; p_rdy = rdy1;
            end
            if (!p_we_n || !p_oe_n) begin
                if (n < 4) log_e[n] = ent(!p_we_n, p_addr, !p_we_n ? p_dq : 16'h0);
                n++;
            end
            if (p_rdy) done = 1'b1;
        end
        check({nm, "_completed"}, 64'(done), 64'(1));
        check({nm, "_access_count"}, 64'(n), 64'(2));
        if (n >= 2) begin
            check({nm, "_low_access"}, 64'(log_e[0]), 64'(e0));
            check({nm, "_high_access"}, 64'(log_e[1]), 64'(e1));
        end
    endtask

    task automatic idle(input int inst);
        @(posedge clk); #1;
        if (inst == 0) begin rd0 = 1'b0; wr0 = 1'b0; end
        else begin rd1 = 1'b0; wr1 = 1'b0; end
    endtask

    initial begin
        rst = 1'b1;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(rdy0), 64'(1));
        check("reset_read_data", 64'(rdata0), 64'(0));
        check("reset_we_n", 64'(we_n0), 64'(1));
        check("reset_oe_n", 64'(oe_n0), 64'(1));
        check("reset_dq_oe", 64'(dqoe0), 64'(0));
        check("reset_sram_addr", 64'(saddr0), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        issue(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, 5,
              ent(1'b1, 18'd0, 16'hBEEF), ent(1'b1, 18'd1, 16'hDEAD), "wr1024");
        idle(0);
        issue(0, 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 5,
              ent(1'b0, 18'd0, 16'h0), ent(1'b0, 18'd1, 16'h0), "rd1024");
        idle(0);
        // back-to-back: the read is presented in the IDLE cycle right after DONE
        issue(0, 1'b0, 1'b1, 32'd1028, 32'h00001234, 32'hDEADBEEF, 5,
              ent(1'b1, 18'd2, 16'h1234), ent(1'b1, 18'd3, 16'h0000), "wr1028");
        issue(0, 1'b1, 1'b0, 32'd1028, 32'h0, 32'h00001234, 5,
              ent(1'b0, 18'd2, 16'h0), ent(1'b0, 18'd3, 16'h0), "rd1028");
        idle(0);
        issue(0, 1'b0, 1'b1, 32'd1032, 32'hA5A55A5A, 32'h00001234, 5,
              ent(1'b1, 18'd4, 16'h5A5A), ent(1'b1, 18'd5, 16'hA5A5), "wr1032");
        idle(0);
        issue(0, 1'b1, 1'b1, 32'd1032, 32'hFFFF0000, 32'hA5A55A5A, 5,
              ent(1'b0, 18'd4, 16'h0), ent(1'b0, 18'd5, 16'h0), "rdwr1032");
        idle(0);

        issue(1, 1'b0, 1'b1, 32'd1032, 32'h12345678, 32'h0, 3,
              ent(1'b1, 18'd4, 16'h5678), ent(1'b1, 18'd5, 16'h1234), "w3_wr1032");
        idle(1);

        // write at 1024 aborted by reset during its HIGH cycle
        @(posedge clk); #1;
        wr1 = 1'b1; addr1 = 32'd1024; wd1 = 32'hDEADBEEF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort_high_we_n", 64'(we_n1), 64'(0));
        check("abort_high_addr", 64'(saddr1), 64'(1));
        rst = 1'b1;
        #1 wr1 = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_state", 64'(dut1.state), 64'(IDLE));
        check("abort_ready", 64'(rdy1), 64'(1));
        check("abort_we_n", 64'(we_n1), 64'(1));
        check("abort_oe_n", 64'(oe_n1), 64'(1));
        check("abort_dq_oe", 64'(dqoe1), 64'(0));

        issue(1, 1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678, 3,
              ent(1'b0, 18'd4, 16'h0), ent(1'b0, 18'd5, 16'h0), "w3_rd1032");
        idle(1);

        repeat (2) @(negedge clk);
        check("queue0_drained", 64'(q0.size()), 64'(0));
        check("queue1_drained", 64'(q1.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side responder for the SARM MEM stage. It accepts one 32-bit word read or write request from the pipeline, performs it as two 16-bit accesses on an external asynchronous SRAM, and signals completion with `ready`. The pipeline's freeze logic holds every stage while `ready` is low. The block sits between `MEM_Stage` and the board SRAM pins and replaces the on-chip data memory.

## Interface
- `WAIT_CYCLES`, default 5: total access latency in clock cycles, from request sampling to the `ready` cycle; legal range 3..15.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rd_en` input 1: word read request (MEM stage `MEMread`); level, held until `ready`.
- `wr_en` input 1: word write request (MEM stage `MEMwrite`); level, held until `ready`.
- `address` input 32: byte address (ALU result); stable while a request is held.
- `write_data` input 32: store value; stable while `wr_en` is held.
- `read_data` output 32: last completed read word.
- `ready` output 1: 1 when no request is pending or the current access completes this cycle.
- `sram_addr` output 18: SRAM halfword address.
- `sram_dq_in` input 16: SRAM data bus, read direction.
- `sram_dq_out` output 16: SRAM data bus, write direction.
- `sram_dq_oe` output 1: tristate enable for `sram_dq_out`, handled at top level.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n` output 1 each: active-low SRAM controls.

## Operation
- States: IDLE, LOW, HIGH, WAIT, DONE. The state register and a 4-bit wait counter are the only sequential control.
- Address map: `word = (address - DATA_BASE) >> 2`, keep 17 bits and wrap silently. LOW uses `sram_addr = {word, 1'b0}`; HIGH uses `{word, 1'b1}`.
- IDLE:
  - If `rd_en | wr_en`, go to LOW.
  - If both are asserted, treat the request as a read and perform no SRAM write.
- LOW:
  - Write: `sram_dq_out = write_data[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0`.
  - Read: `sram_oe_n = 0`; capture `sram_dq_in` into an internal low-half register at the end of the cycle.
  - Always go to HIGH.
- HIGH:
  - Same as LOW but with `write_data[31:16]`.
  - On a read, at the end of the cycle load `read_data <= {sram_dq_in, low_half}`.
  - If `WAIT_CYCLES == 3`, go to DONE. Otherwise load the counter with `WAIT_CYCLES-4` and go to WAIT.
- WAIT: decrement the counter; go to DONE when the counter is 0. SRAM is idle.
- DONE: `ready = 1`; go to IDLE unconditionally.
- Outside LOW/HIGH: `sram_we_n = sram_oe_n = 1`, `sram_dq_oe = 0`. `sram_ce_n`, `sram_ub_n` and `sram_lb_n` are tied to 0.
- `ready = (state == DONE) | (state == IDLE & ~rd_en & ~wr_en)`, combinational.
- Back-to-back accesses: after DONE the state returns to IDLE. The next instruction's request, if present, is sampled there and the sequence restarts; `ready` is 0 in that IDLE cycle.
- `read_data` changes only at the end of a read's HIGH cycle. Writes never modify it.

## Timing
- Request first present in an IDLE cycle, edge E0 follows.
  - LOW after E0, HIGH after E1, WAIT occupies `WAIT_CYCLES-3` cycles, DONE after E(`WAIT_CYCLES`-1).
  - `ready` is high during the DONE cycle; the pipeline advances at E(`WAIT_CYCLES`).
- Reset values (asynchronous, immediate): state IDLE, counter 0, `read_data = 0`, low-half register 0, `sram_we_n = sram_oe_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`.
  - `ready` follows `~(rd_en | wr_en)` during reset.
- Reset during LOW or HIGH of a write aborts the access. The SRAM may hold a partially written word, which is acceptable.
- Request dropped mid-access (illegal): the sequence still runs to DONE.

## Structure
- Shared package `sarm_pkg`:
  - state enum `sram_state_t`
  - `DATA_BASE = 32'd1024`
  - `SRAM_ADDR_W = 18`
  - `SRAM_DATA_W = 16`
- Single module with no sub-module. The tristate bus is resolved in the SARM top level.
- The top level ties `freeze = hazard | ~ready` and feeds `read_data` to `MEM_Stage_Reg`.

## Test plan
- Reset with `rd_en = wr_en = 0` -> `ready = 1`, `read_data = 0`, `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`.
- `wr_en`, `address = 1024`, `write_data = 0xDEADBEEF`, `WAIT_CYCLES = 5` -> `sram_addr = 0` with dq `0xBEEF` and `we_n = 0` for one cycle, then `sram_addr = 1` with dq `0xBEEF`→`0xDEAD`, i.e. dq `0xDEAD` and `we_n = 0` for one cycle; `ready` high exactly 5 cycles after the request is first seen, for 1 cycle.
- Read `address = 1024` after the previous write, with an SRAM model behind the pins -> `read_data = 0xDEADBEEF` from the HIGH edge onward, and `ready` pulses as above.
- Consecutive held requests (write `0x0000_1234` to 1028, then read 1028) -> two full sequences separated by one IDLE cycle with `ready = 0`; read returns `0x00001234`; `sram_addr` is 2 then 3.
- `rd_en = wr_en = 1` at `address = 1032` -> no cycle with `sram_we_n = 0`; behaves as a read.
- `rst` pulsed during HIGH of a write -> next cycle state is IDLE, all controls inactive; a subsequent read completes normally with `WAIT_CYCLES = 3`, with `ready` 3 cycles after the request.
